// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a parallel pattern into an SDFF chain, pulses one
// capture cycle, then unloads the captured response into a parallel word.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic [CHAIN_LEN-1:0] RESPONSE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2:0]           o_dbg_state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_UNLOAD  = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  // Handshake: START is a level sampled only in IDLE; the accepting edge latches
  // PATTERN. DONE is a one-cycle pulse qualifying RESPONSE; no backpressure.

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CHAIN_LEN-1:0] r_shreg;
  logic [CHAIN_LEN-1:0] r_resp;
  logic                 r_se;
  logic                 r_si;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_last;

  assign w_last = (r_cnt == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_resp  <= '0;
      r_se    <= 1'b0;
      r_si    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_se   <= 1'b0;
          r_si   <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (START) begin
            r_state <= ST_SHIFT;
            r_shreg <= PATTERN;
            r_cnt   <= '0;
            r_se    <= 1'b1;
            r_si    <= PATTERN[CHAIN_LEN-1];
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // SI is registered one cycle ahead, so the next bit comes from shreg[N-2].
          if (w_last) begin
            r_state <= ST_CAPTURE;
            r_cnt   <= '0;
            r_se    <= 1'b0;
            r_si    <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_shreg <= {r_shreg[CHAIN_LEN-2:0], 1'b0};
            r_si    <= r_shreg[CHAIN_LEN-2];
          end
        end
        ST_CAPTURE: begin
          r_state <= ST_UNLOAD;
          r_cnt   <= '0;
          r_se    <= 1'b1;
          r_si    <= 1'b0;
        end
        ST_UNLOAD: begin
          // Tail cell arrives first and ends up in the MSB after N shifts.
          r_resp <= {r_resp[CHAIN_LEN-2:0], SO};
          if (w_last) begin
            r_state <= ST_FINISH;
            r_cnt   <= '0;
            r_se    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_se    <= 1'b0;
          r_si    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign SE          = r_se;
  assign SI          = r_si;
  assign RESPONSE    = r_resp;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a 4-cell chain whose D pins are tied
// to their own QN, so a capture inverts the shifted-in pattern.
module tb_scan_chain_ctrl;

  localparam int N = 4;

  logic         CK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [N-1:0] PATTERN = '0;
  logic         SO;
  logic         SE;
  logic         SI;
  logic [N-1:0] RESPONSE;
  logic         BUSY;
  logic         DONE;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad = 0;

  logic [N-1:0] chain_q = '0;

  always #5 CK = ~CK;

  // Chain model: scan shift when SE=1, otherwise each cell captures its own QN.
  always @(posedge CK) begin
    if (SE) chain_q <= {chain_q[N-2:0], SI};
    else    chain_q <= ~chain_q;
  end
  assign SO = chain_q[N-1];

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .CK(CK), .RST(RST), .START(START), .PATTERN(PATTERN), .SO(SO),
    .SE(SE), .SI(SI), .RESPONSE(RESPONSE), .BUSY(BUSY), .DONE(DONE),
    .o_dbg_state(dbg_state)
  );

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; START = 1'b0; PATTERN = '0;
    tick; tick;
    total++;
    if ({SE, SI, BUSY, DONE, RESPONSE, dbg_state} !== 11'b0) begin
      bad++;
      $display("FAIL reset_state: got se=%b si=%b busy=%b done=%b resp=%b st=%0d want all 0",
               SE, SI, BUSY, DONE, RESPONSE, dbg_state);
    end
    RST = 1'b0;
  endtask

  task automatic test_basic;
    logic [N-1:0] si_seq;
    logic         exp_se;
    logic         exp_si;
    si_seq = 4'b1011;
    PATTERN = 4'b1011; START = 1'b1;
    tick;
    START = 1'b0; PATTERN = 4'b0000;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      exp_se = (cyc != 5);
      exp_si = (cyc <= 4) ? si_seq[4-cyc] : 1'b0;
      total++;
      if ({SE, SI, BUSY, DONE} !== {exp_se, exp_si, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL basic_cycle%0d: got se=%b si=%b busy=%b done=%b want se=%b si=%b busy=1 done=0",
                 cyc, SE, SI, BUSY, DONE, exp_se, exp_si);
      end
      tick;
    end
    total++;
    if ({DONE, BUSY, SE, RESPONSE} !== {3'b100, 4'b0100}) begin
      bad++;
      $display("FAIL basic_done: got done=%b busy=%b se=%b resp=%b want done=1 busy=0 se=0 resp=0100",
               DONE, BUSY, SE, RESPONSE);
    end
    tick;
    total++;
    if ({DONE, RESPONSE} !== {1'b0, 4'b0100}) begin
      bad++;
      $display("FAIL basic_after_done: got done=%b resp=%b want done=0 resp=0100", DONE, RESPONSE);
    end
  endtask

  task automatic test_idle_hold;
    int errs;
    RST = 1'b1; tick; RST = 1'b0;
    errs = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if ({SE, BUSY, DONE, RESPONSE} !== 7'b0) errs++;
      tick;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL idle_hold: got %0d nonzero cycles want 0", errs);
    end
  endtask

  task automatic test_ignored_start;
    int dones;
    dones = 0;
    PATTERN = 4'b0110; START = 1'b1;
    tick;
    START = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (DONE) dones++;
      if (cyc == 10) begin
        total++;
        if ({DONE, RESPONSE} !== {1'b1, 4'b1001}) begin
          bad++;
          $display("FAIL ignored_done: got done=%b resp=%b want done=1 resp=1001", DONE, RESPONSE);
        end
      end
      START = (cyc == 3 || cyc == 10);
      if (cyc == 3) PATTERN = 4'b1111;
      tick;
    end
    START = 1'b0;
    if (DONE) dones++;
    total++;
    if ({BUSY, DONE, dbg_state} !== 5'b0 || dones !== 1) begin
      bad++;
      $display("FAIL ignored_cycle11: got busy=%b done=%b st=%0d dones=%0d want busy=0 done=0 st=0 dones=1",
               BUSY, DONE, dbg_state, dones);
    end
    PATTERN = 4'b0011; START = 1'b1;
    tick;
    START = 1'b0;
    total++;
    if ({BUSY, SE, SI} !== 3'b110) begin
      bad++;
      $display("FAIL restart_accept: got busy=%b se=%b si=%b want busy=1 se=1 si=0", BUSY, SE, SI);
    end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      if (cyc <= 6) begin
        total++;
        if (RESPONSE !== 4'b1001) begin
          bad++;
          $display("FAIL resp_hold_cycle%0d: got resp=%b want 1001", cyc, RESPONSE);
        end
      end
      tick;
    end
    total++;
    if ({DONE, RESPONSE} !== {1'b1, 4'b1100}) begin
      bad++;
      $display("FAIL restart_done: got done=%b resp=%b want done=1 resp=1100", DONE, RESPONSE);
    end
    tick;
  endtask

  task automatic test_reset_mid_unload;
    int dones;
    int cyc;
    PATTERN = 4'b1111; START = 1'b1;
    tick;
    START = 1'b0;
    for (int c = 1; c <= 6; c++) tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    total++;
    if ({SE, BUSY, DONE, RESPONSE, dbg_state} !== 10'b0) begin
      bad++;
      $display("FAIL rst_unload: got se=%b busy=%b done=%b resp=%b st=%0d want all 0",
               SE, BUSY, DONE, RESPONSE, dbg_state);
    end
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      if (DONE || BUSY) dones++;
      tick;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL rst_no_done: got %0d active cycles want 0", dones);
    end
    PATTERN = 4'b0000; START = 1'b1;
    tick;
    START = 1'b0;
    cyc = 1;
    while (!DONE && cyc < 30) begin
      tick;
      cyc++;
    end
    total++;
    if (cyc !== 10 || RESPONSE !== 4'b1111) begin
      bad++;
      $display("FAIL rst_recover: got done_cycle=%0d resp=%b want done_cycle=10 resp=1111", cyc, RESPONSE);
    end
    tick;
  endtask

  task automatic test_rst_start_same;
    RST = 1'b1; START = 1'b1; PATTERN = 4'b1010;
    tick;
    RST = 1'b0; START = 1'b0;
    total++;
    if ({BUSY, SE, dbg_state} !== 5'b0) begin
      bad++;
      $display("FAIL rst_start_cycle1: got busy=%b se=%b st=%0d want busy=0 se=0 st=0", BUSY, SE, dbg_state);
    end
    tick;
    total++;
    if ({BUSY, SE} !== 2'b0) begin
      bad++;
      $display("FAIL rst_start_cycle2: got busy=%b se=%b want busy=0 se=0", BUSY, SE);
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] pats [4];
    logic [N-1:0] exps [4];
    int cyc;
    pats = '{4'b0000, 4'b1000, 4'b0001, 4'b0101};
    exps = '{4'b1111, 4'b0111, 4'b1110, 4'b1010};
    for (int i = 0; i < 4; i++) begin
      PATTERN = pats[i]; START = 1'b1;
      tick;
      START = 1'b0;
      cyc = 1;
      while (!DONE && cyc < 30) begin
        tick;
        cyc++;
      end
      total++;
      if (cyc !== 10 || RESPONSE !== exps[i]) begin
        bad++;
        $display("FAIL b2b_%0d: got done_cycle=%0d resp=%b want done_cycle=10 resp=%b",
                 i, cyc, RESPONSE, exps[i]);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_idle_hold;
    test_ignored_start;
    test_reset_mid_unload;
    test_rst_start_same;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencer for a single scan chain built from SDFF_X1 cells (D, SE, SI, CK, Q, QN). On request it shifts a parallel test pattern serially into the chain and pulses one functional capture cycle. It then shifts the captured response out and presents it as a parallel word. The block sits between the test access logic and the chain: it drives the chain's shared SE and its head SI, and it observes the tail Q as SO.

## Interface
- CHAIN_LEN, 8, number of SDFF_X1 cells in the chain (≥ 2)
- CNT_W, $clog2(CHAIN_LEN+1), width of the internal shift counter

Ports:
- CK  input  1  clock; also drives CK of every chain cell
- RST  input  1  synchronous, active-high reset
- START  input  1  request; sampled only in IDLE
- PATTERN  input  CHAIN_LEN  stimulus word, latched on the accepted START
- SO  input  1  Q of the last chain cell (cell CHAIN_LEN-1)
- SE  output  1  scan enable to all chain cells, registered
- SI  output  1  serial data to the SI pin of cell 0, registered
- RESPONSE  output  CHAIN_LEN  captured word, valid when DONE=1, held until the next accepted START
- BUSY  output  1  high in SHIFT, CAPTURE and UNLOAD
- DONE  output  1  one-cycle pulse when RESPONSE is valid

## Operation
- States: IDLE → SHIFT → CAPTURE → UNLOAD → FINISH → IDLE.
- IDLE: SE=0, SI=0, BUSY=0.
  - START=1 latches PATTERN into the shift register and clears the counter.
  - Next state is SHIFT.
- SHIFT (CHAIN_LEN cycles): SE=1.
  - SI carries PATTERN[CHAIN_LEN-1] in the first cycle, then descending bits, ending with PATTERN[0].
  - After the last shift edge, chain cell k holds PATTERN[k].
- CAPTURE (exactly 1 cycle): SE=0, SI=0. The chain loads its D inputs on the edge that ends this cycle.
- UNLOAD (CHAIN_LEN cycles): SE=1, SI=0.
  - SO is sampled on the edge that ends each cycle.
  - The first sample goes to RESPONSE[CHAIN_LEN-1], the last to RESPONSE[0], so RESPONSE[k] equals the value captured by cell k.
- FINISH (1 cycle): DONE=1, BUSY=0, SE=0, SI=0. RESPONSE holds its final value. Next state is IDLE.
- START outside IDLE is ignored, with no queueing; PATTERN changes after acceptance have no effect.
- START sampled in FINISH is ignored. The earliest back-to-back START is accepted in the IDLE cycle after DONE.
- RESPONSE is not updated during SHIFT or CAPTURE; it shows the previous result until UNLOAD begins overwriting it.
- Counter counts 0..CHAIN_LEN-1 in SHIFT and UNLOAD and is cleared on each state change. No wrap-around beyond CHAIN_LEN-1 occurs.

## Timing
- Reset values (RST=1 at an edge, in any state): state=IDLE, SE=0, SI=0, BUSY=0, DONE=0, RESPONSE=0, counter=0.
  - A reset mid-SHIFT or mid-UNLOAD abandons the operation.
  - No DONE is produced, and SE is low from the first post-reset cycle.
- RST takes priority over START in the same cycle.
- All outputs are registered and change only on rising CK. SE and SI are stable for a full cycle before the chain samples them.
- With the START-accepting edge as edge 0:
  - SHIFT occupies cycles 1..N, CAPTURE cycle N+1, UNLOAD cycles N+2..2N+1.
  - DONE is high in cycle 2N+2.
  - Total latency from START to DONE is 2N+2 cycles (N=CHAIN_LEN).
- BUSY rises in cycle 1 and falls at the start of cycle 2N+2 (FINISH).

## Test plan
- Bench: CHAIN_LEN=4; chain of four SDFF_X1 cells, with cell k's D tied to the QN of cell k, so capture inverts the chain contents.
- PATTERN=4'b1011, START pulse:
  - SI sequence during SHIFT is 1,0,1,1.
  - SE is 1,1,1,1,0,1,1,1,1 over cycles 1..9.
  - DONE is high in cycle 10 with RESPONSE=4'b0100.
- After reset, hold START low for 20 cycles: SE=0, BUSY=0, DONE=0, RESPONSE=0 throughout.
- PATTERN=4'b0110, START, then START again at cycles 3 and 10 (FINISH):
  - Both extra STARTs are ignored; exactly one DONE pulse occurs, with RESPONSE=4'b1001.
  - START at cycle 11 (IDLE) is accepted.
- PATTERN=4'b1111, assert RST in cycle 7 (UNLOAD):
  - Next cycle SE=0, BUSY=0, RESPONSE=0.
  - No DONE pulse follows.
  - A new START with PATTERN=4'b0000 then completes with RESPONSE=4'b1111.
- RST and START high in the same IDLE cycle: the request is not accepted, and BUSY stays 0 in the following cycle.
